// File: rtl/demux_rr_sched.sv
// demux_rr_sched: single-entry buffered controller for a 1:8 demux.
// Words arrive on a valid/ready interface, are held in one buffer and
// steered to a sink channel either in round-robin order (stalled sinks are
// skipped after a timeout) or to an explicit destination (the word is
// dropped if that destination stays stalled for the full timeout).

module demux_rr_sched #(
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_dest,
    output logic              in_ready,
    output logic [2:0]        sel,
    output logic [7:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [7:0]        out_ready,
    output logic              busy,
    output logic              drop
);

    // Stall counter width; at least one bit even when WAIT_MAX is 1.
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        sel_next;
    logic [2:0]        ptr;
    logic [2:0]        ptr_next;
    logic [2:0]        rr_target;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_next;
    logic [DATA_W-1:0] data_next;
    logic              cur_mode;
    logic              mode_next;
    logic              drop_next;
    logic              deliver;
    logic              capture;
    logic              stall;
    logic              wait_last;

    // Handshake terms: a held word leaves when its selected sink is ready,
    // and a new word may enter whenever the buffer is empty or emptying.
    assign busy      = (state == HOLD);
    assign deliver   = busy & out_ready[sel];
    assign stall     = busy & ~out_ready[sel];
    assign in_ready  = ~rst & (~busy | deliver);
    assign capture   = in_valid & in_ready;
    assign wait_last = (wait_cnt == CNT_LAST);
    assign out_valid = busy ? (8'b1 << sel) : 8'b0;

    // Round-robin target for a newly captured word: the channel after the one
    // just served if a delivery happens this cycle, otherwise the stored pointer.
    assign rr_target = deliver ? (sel + 3'd1) : ptr;

    // Next-state and next-register computation for capture, delivery and stall.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        ptr_next   = ptr;
        wait_next  = wait_cnt;
        data_next  = out_data;
        mode_next  = cur_mode;
        drop_next  = 1'b0;

        if (deliver) begin
            ptr_next = sel + 3'd1;
        end

        if (capture) begin
            state_next = HOLD;
            data_next  = in_data;
            wait_next  = '0;
            mode_next  = mode;
            sel_next   = mode ? in_dest : rr_target;
        end else if (deliver) begin
            state_next = IDLE;
            wait_next  = '0;
        end else if (stall) begin
            if (!wait_last) begin
                wait_next = wait_cnt + CNT_W'(1);
            end else if (!cur_mode) begin
                sel_next  = sel + 3'd1;
                wait_next = '0;
            end else begin
                state_next = IDLE;
                wait_next  = '0;
                drop_next  = 1'b1;
            end
        end
    end

    // State register with synchronous reset; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 3'd0;
            ptr      <= 3'd0;
            wait_cnt <= '0;
            out_data <= '0;
            cur_mode <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            ptr      <= ptr_next;
            wait_cnt <= wait_next;
            out_data <= data_next;
            cur_mode <= mode_next;
            drop     <= drop_next;
        end
    end

endmodule
